// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter
//   Shares one single-port synchronous RAM between the VGA text fetch path
//   and the CPU. VGA announces a memory cycle one clock ahead on
//   i_vga_access; the following clock is reserved for it with zero wait.
//   The CPU fills every other cycle through a cs/we/ack handshake.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_vga_addr/cs/access    VGA fetch request (access = cs next clock)
//   o_vga_dat               VGA read data, the clock after i_vga_cs
//   i_cpu_addr/dat/cs/we    CPU request, held until o_cpu_ack
//   o_cpu_dat, o_cpu_ack    CPU read data and one-cycle completion pulse
//   o_vga_err               sticky: i_vga_cs without prior i_vga_access
//   o_mem_*                 RAM port (addr, write data, cs, we)
//   i_mem_dat               RAM read data, one clock after o_mem_cs
//
// CPU FSM
//   state | meaning
//   IDLE  | waiting for a CPU request in a non-granted cycle
//   WAIT  | RAM read data arriving; captured for reads
//   ACK   | o_cpu_ack high for exactly this cycle

module vga_mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [AW-1:0] i_vga_addr,
    input  logic          i_vga_cs,
    input  logic          i_vga_access,
    output logic [DW-1:0] o_vga_dat,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_dat,
    input  logic          i_cpu_cs,
    input  logic          i_cpu_we,
    output logic [DW-1:0] o_cpu_dat,
    output logic          o_cpu_ack,
    output logic          o_vga_err,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_dat,
    output logic          o_mem_cs,
    output logic          o_mem_we,
    input  logic [DW-1:0] i_mem_dat
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          vga_grant_q;
    logic          ack_q, ack_d;
    logic          we_q, we_d;
    logic [DW-1:0] cpu_dat_q, cpu_dat_d;
    logic          vga_err_q, vga_err_d;
    logic          cpu_issue;

    // Issue is gated by reset so an aborted cycle never reaches the RAM.
    assign cpu_issue = (state_q == ST_IDLE) && i_cpu_cs && !vga_grant_q && !i_reset;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            vga_grant_q <= 1'b0;
            ack_q       <= 1'b0;
            we_q        <= 1'b0;
            cpu_dat_q   <= '0;
            vga_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vga_grant_q <= i_vga_access;
            ack_q       <= ack_d;
            we_q        <= we_d;
            cpu_dat_q   <= cpu_dat_d;
            vga_err_q   <= vga_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        we_d      = we_q;
        cpu_dat_d = cpu_dat_q;
        vga_err_d = vga_err_q | (i_vga_cs & ~vga_grant_q);
        case (state_q)
            ST_IDLE: begin
                if (cpu_issue) begin
                    state_d = ST_WAIT;
                    we_d    = i_cpu_we;
                end
            end
            ST_WAIT: begin
                if (!we_q) begin
                    cpu_dat_d = i_mem_dat;
                end
                ack_d   = 1'b1;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM port mux. An unannounced i_vga_cs is not served: the port then
    // follows the CPU/idle rule.
    always_comb begin
        o_mem_cs   = 1'b0;
        o_mem_we   = 1'b0;
        o_mem_addr = '0;
        o_mem_dat  = '0;
        if (vga_grant_q) begin
            o_mem_cs   = i_vga_cs;
            o_mem_addr = i_vga_addr;
        end else if (cpu_issue) begin
            o_mem_cs   = 1'b1;
            o_mem_we   = i_cpu_we;
            o_mem_addr = i_cpu_addr;
            o_mem_dat  = i_cpu_dat;
        end
    end

    assign o_vga_dat = i_mem_dat;
    assign o_cpu_dat = cpu_dat_q;
    assign o_cpu_ack = ack_q;
    assign o_vga_err = vga_err_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scoreboard bench for vga_mem_arbiter: drivers push expected CPU/VGA read
// data into queues; a negedge monitor pops and compares whenever the DUT
// presents an ack or VGA data, and also checks grant-cycle mux behaviour
// and the sticky error flag every cycle.

module tb_vga_mem_arbiter;

    logic        i_clk;
    logic        i_reset;
    logic [15:0] i_vga_addr;
    logic        i_vga_cs;
    logic        i_vga_access;
    logic [15:0] o_vga_dat;
    logic [15:0] i_cpu_addr;
    logic [15:0] i_cpu_dat;
    logic        i_cpu_cs;
    logic        i_cpu_we;
    logic [15:0] o_cpu_dat;
    logic        o_cpu_ack;
    logic        o_vga_err;
    logic [15:0] o_mem_addr;
    logic [15:0] o_mem_dat;
    logic        o_mem_cs;
    logic        o_mem_we;
    logic [15:0] i_mem_dat;

    vga_mem_arbiter #(.AW(16), .DW(16)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_vga_addr   (i_vga_addr),
        .i_vga_cs     (i_vga_cs),
        .i_vga_access (i_vga_access),
        .o_vga_dat    (o_vga_dat),
        .i_cpu_addr   (i_cpu_addr),
        .i_cpu_dat    (i_cpu_dat),
        .i_cpu_cs     (i_cpu_cs),
        .i_cpu_we     (i_cpu_we),
        .o_cpu_dat    (o_cpu_dat),
        .o_cpu_ack    (o_cpu_ack),
        .o_vga_err    (o_vga_err),
        .o_mem_addr   (o_mem_addr),
        .o_mem_dat    (o_mem_dat),
        .o_mem_cs     (o_mem_cs),
        .o_mem_we     (o_mem_we),
        .i_mem_dat    (i_mem_dat)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int checks = 0;
    int errors = 0;

    logic [15:0] cpu_q[$];
    logic [15:0] vga_q[$];

    // Default RAM contents; 0x1234 preloaded with 0xBEEF.
    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'hA5A5);
    endfunction

    // RAM model (1-cycle read latency)
    logic [15:0] ram    [0:65535];
    bit          ram_wr [0:65535];
    always @(posedge i_clk) begin
        if (o_mem_cs) begin
            i_mem_dat <= ram_wr[o_mem_addr] ? ram[o_mem_addr] : init_val(o_mem_addr);
            if (o_mem_we) begin
                ram[o_mem_addr]    <= o_mem_dat;
                ram_wr[o_mem_addr] <= 1'b1;
            end
        end
    end

    // Bench-side shadow of what the stimulus has written
    logic [15:0] shadow    [0:65535];
    bit          shadow_wr [0:65535];
    logic [15:0] last_rd;
    logic        acc_prev_drv;

    function automatic logic [15:0] sh_get(input logic [15:0] a);
        return shadow_wr[a] ? shadow[a] : init_val(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic vga_cycle(input logic acc, input logic cs, input logic [15:0] a);
        i_vga_access = acc;
        i_vga_cs     = cs;
        i_vga_addr   = a;
        if (cs && acc_prev_drv) vga_q.push_back(sh_get(a));
        acc_prev_drv = acc;
        next_cycle();
    endtask

    // exp_lat: exact clocks from cs rise to ack; -1 means "at most 4".
    task automatic cpu_op(input logic [15:0] a, input logic [15:0] d, input logic we,
                          input int exp_lat);
        int n;
        bit done;
        logic [15:0] e;
        i_cpu_addr = a;
        i_cpu_dat  = d;
        i_cpu_we   = we;
        i_cpu_cs   = 1'b1;
        if (we) begin
            shadow[a]    = d;
            shadow_wr[a] = 1'b1;
            e = last_rd;
        end else begin
            e = sh_get(a);
            last_rd = e;
        end
        cpu_q.push_back(e);
        n = 0;
        done = 0;
        while (!done) begin
            @(negedge i_clk);
            if (exp_lat == 2 && n == 0) begin
                chk("issue_mem_cs", o_mem_cs, 1);
                chk("issue_mem_addr", o_mem_addr, a);
                chk("issue_mem_we", o_mem_we, we);
                chk("issue_mem_dat", o_mem_dat, d);
            end else if (exp_lat == 2) begin
                chk("no_mem_after_issue", o_mem_cs, 0);
            end
            if (o_cpu_ack) begin
                done = 1;
            end else begin
                n++;
                if (n > 20) begin
                    checks++;
                    errors++;
                    $display("FAIL cpu_ack_timeout actual=none required=ack");
                    done = 1;
                end
            end
        end
        if (exp_lat >= 0) chk("cpu_latency", n, exp_lat);
        else              chk("cpu_latency_le4", (n <= 4), 1);
        next_cycle();
        i_cpu_cs = 1'b0;
        i_cpu_we = 1'b0;
    endtask

    // Monitor / scoreboard
    initial begin
        logic gr, acc_p, vpend, err_m;
        acc_p = 0; vpend = 0; err_m = 0;
        forever begin
            @(negedge i_clk);
            if (vpend) begin
                if (vga_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL vga_unexpected actual=%h required=none", o_vga_dat);
                end else begin
                    chk("vga_dat", o_vga_dat, vga_q.pop_front());
                end
            end
            if (o_cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_ack actual=1 required=0");
                end else begin
                    chk("cpu_dat", o_cpu_dat, cpu_q.pop_front());
                end
            end
            chk("vga_err", o_vga_err, err_m);
            gr = acc_p;
            if (gr) begin
                chk("grant_mem_cs", o_mem_cs, i_vga_cs);
                chk("grant_mem_we", o_mem_we, 0);
                if (i_vga_cs) chk("grant_mem_addr", o_mem_addr, i_vga_addr);
            end
            vpend = gr && i_vga_cs && !i_reset;
            acc_p = !i_reset && i_vga_access;
            err_m = !i_reset && (err_m || (i_vga_cs && !gr));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic prev;
        logic [15:0] x;
        i_reset = 1; i_vga_addr = 0; i_vga_cs = 0; i_vga_access = 0;
        i_cpu_addr = 16'h0077; i_cpu_dat = 16'h1111; i_cpu_cs = 1; i_cpu_we = 1;
        last_rd = 0; acc_prev_drv = 0;

        // Issue suppressed while reset is high, even with cs asserted.
        next_cycle();
        next_cycle();
        @(negedge i_clk);
        chk("reset_no_issue", o_mem_cs, 0);
        next_cycle();
        i_reset = 0; i_cpu_cs = 0; i_cpu_we = 0;
        @(negedge i_clk);
        chk("rst_ack", o_cpu_ack, 0);
        chk("rst_cpu_dat", o_cpu_dat, 0);
        chk("rst_err", o_vga_err, 0);
        chk("rst_mem_cs", o_mem_cs, 0);
        next_cycle();

        // Idle read, write, read-back
        cpu_op(16'h1234, 16'h0000, 0, 2);
        cpu_op(16'h0010, 16'h55AA, 1, 2);
        cpu_op(16'h0010, 16'h0000, 0, 2);
        next_cycle();

        // Conflict: VGA granted in the cycle the CPU raises cs
        fork
            begin
                vga_cycle(1, 0, 16'h0000);
                vga_cycle(0, 1, 16'h1005);
                vga_cycle(0, 0, 16'h0000);
            end
            begin
                next_cycle();
                cpu_op(16'h0200, 16'h0000, 0, 3);
            end
        join
        next_cycle();

        // Text-line pattern: access at x%8==3 and 4, continuous CPU reads
        fork
            begin
                prev = 0;
                for (int i = 0; i < 64; i++) begin
                    x = 16'(i);
                    vga_cycle((x[2:0] == 3'd3) || (x[2:0] == 3'd4), prev, 16'h2000 + x);
                    prev = (x[2:0] == 3'd3) || (x[2:0] == 3'd4);
                end
                vga_cycle(0, 0, 16'h0000);
            end
            begin
                for (int j = 0; j < 8; j++) begin
                    cpu_op(16'h3000 + 16'(j), 16'h0000, 0, -1);
                end
            end
        join
        next_cycle();

        // Protocol error: cs without prior access, sticky until reset
        vga_cycle(0, 0, 16'h0000);
        vga_cycle(0, 1, 16'h0042);
        i_vga_cs = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk("err_sticky", o_vga_err, 1);
            next_cycle();
        end

        // Reset during WAIT: no ack, everything back to reset values
        i_cpu_addr = 16'h0100; i_cpu_we = 0; i_cpu_cs = 1;
        next_cycle();
        i_reset = 1; i_cpu_cs = 0;
        next_cycle();
        i_reset = 0;
        last_rd = 0;
        @(negedge i_clk);
        chk("wait_rst_ack", o_cpu_ack, 0);
        chk("wait_rst_cpu_dat", o_cpu_dat, 0);
        chk("wait_rst_err", o_vga_err, 0);
        chk("wait_rst_mem_cs", o_mem_cs, 0);
        next_cycle();
        repeat (3) next_cycle();

        // FSM back in IDLE: a fresh read completes normally
        cpu_op(16'h0010, 16'h0000, 0, 2);
        repeat (2) next_cycle();

        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("vga_q_drained", vga_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_mem_arbiter.md
# vga_mem_arbiter

Shared-memory arbiter between the monochrome VGA text controller and the CPU. It gives the VGA fetch path guaranteed, zero-wait access to a single-port synchronous RAM in the cycles the controller announces one cycle in advance. CPU reads and writes fill all remaining cycles through a cs/we/ack handshake. It sits between the two bus masters and the 64K×16 video/font RAM.

## Interface
- AW, 16, address width (RAM word address).
- DW, 16, data width.
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_vga_addr  in  AW  VGA fetch address, valid while i_vga_cs.
- i_vga_cs  in  1  VGA memory cycle this clock.
- i_vga_access  in  1  VGA will assert i_vga_cs in the next clock.
- o_vga_dat  out  DW  read data, valid the clock after i_vga_cs.
- i_cpu_addr  in  AW  CPU address, held stable until o_cpu_ack.
- i_cpu_dat  in  DW  CPU write data, held stable until o_cpu_ack.
- i_cpu_cs  in  1  CPU request, held until o_cpu_ack.
- i_cpu_we  in  1  1 = write, 0 = read, held with i_cpu_cs.
- o_cpu_dat  out  DW  registered CPU read data, valid with o_cpu_ack.
- o_cpu_ack  out  1  one-cycle completion pulse.
- o_vga_err  out  1  sticky: i_vga_cs seen without prior i_vga_access.
- o_mem_addr  out  AW  RAM address.
- o_mem_dat  out  DW  RAM write data.
- o_mem_cs  out  1  RAM cycle this clock.
- o_mem_we  out  1  RAM write strobe.
- i_mem_dat  in  DW  RAM read data, valid the clock after o_mem_cs (1-cycle latency).

## Operation
- r_vga_grant <= i_vga_access each clock. A high value reserves the current cycle for VGA.
- Memory mux (combinational):
  - If r_vga_grant: o_mem_cs = i_vga_cs, o_mem_addr = i_vga_addr, o_mem_we = 0, o_mem_dat = 0.
  - Else if CPU issue (below): o_mem_cs = 1, o_mem_we = i_cpu_we, o_mem_addr = i_cpu_addr, o_mem_dat = i_cpu_dat.
  - Else all mem outputs are 0.
- o_vga_dat = i_mem_dat, passthrough with no register.
- CPU FSM states IDLE, WAIT, ACK:
  - IDLE: CPU issue = i_cpu_cs && !r_vga_grant && !i_reset. On issue go to WAIT; otherwise stay in IDLE. A blocked request stays pending with no timeout.
  - WAIT: no memory cycle is issued. o_cpu_dat <= i_mem_dat if read, unchanged if write. Go to ACK.
  - ACK: o_cpu_ack = 1 (registered, high exactly this cycle). No issue. Go to IDLE.
- The CPU deasserts i_cpu_cs in the clock after o_cpu_ack. If i_cpu_cs is still high in IDLE, it is a new request.
- o_vga_err <= 1 when i_vga_cs && !r_vga_grant. Only reset clears it. In that cycle VGA is not served: the mux still follows the CPU/idle rule, and o_vga_dat is undefined next cycle.
- Simultaneous i_cpu_cs and r_vga_grant: VGA wins, and the CPU issues at the first non-granted IDLE cycle.
- Back-to-back grants (i_vga_access high for k cycles) block the CPU for k cycles. A CPU operation already in WAIT or ACK is unaffected because it no longer uses the RAM.

## Timing
- Reset values: r_vga_grant = 0, state = IDLE, o_cpu_ack = 0, o_cpu_dat = 0, o_vga_err = 0. The mem outputs are therefore 0 in the cycle after reset unless the CPU issues.
- Reset mid-transaction: the FSM returns to IDLE, no ack is produced for the aborted access, and issue is suppressed in any cycle where i_reset is high. A write that issued before reset is not undone.
- VGA latency: i_vga_access at N-1, address at N, data on o_vga_dat during N+1.
- CPU latency: the issue cycle is C. Data is registered at the end of C+1, and o_cpu_ack and o_cpu_dat are valid in C+2. A best-case request is acked 2 clocks after i_cpu_cs first rises, plus 1 clock per blocked cycle.
- CPU throughput: at most one operation per 3 clocks (issue, WAIT, ACK). cs low in the post-ack cycle gives a 4-clock minimum loop.

## Test plan
- Idle CPU read: RAM[0x1234] = 0xBEEF, i_cpu_cs = 1, i_cpu_we = 0 at cycle 0 with no VGA -> o_mem_cs at cycle 0 with addr 0x1234; o_cpu_ack = 1 and o_cpu_dat = 0xBEEF at cycle 2 only.
- CPU write: addr 0x0010, dat 0x55AA -> o_mem_we = 1 for one cycle at issue and ack 2 cycles later; a subsequent read of 0x0010 returns 0x55AA.
- Conflict: i_vga_access at cycle 0, i_vga_cs with addr 0x1005 at cycle 1, CPU cs raised at cycle 1 -> cycle 1 mem addr is 0x1005 and o_vga_dat is RAM[0x1005] at cycle 2; the CPU issues at cycle 2 and acks at cycle 4.
- VGA text-line pattern: i_vga_access pulses at x%8 == 3 and at the following phase, with continuous CPU reads -> every VGA cycle is served with correct data, the CPU never accesses RAM in a granted cycle, and each CPU read completes within 2 + 2 clocks.
- Protocol error: i_vga_cs without i_vga_access in the preceding cycle -> o_vga_err rises the next cycle and stays high until i_reset.
- Reset during WAIT -> no o_cpu_ack, state returns to IDLE, and all outputs hold their reset values in the following cycle.
